// File: rtl/sif_pkg.sv
// Shared types and constants for the SIF xa bus arbiter.
package sif_pkg;

  localparam int SIF_AW = 16;
  localparam int SIF_DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sif_state_e;

  function automatic logic [2:0] next_ptr(input logic [2:0] idx, input int n);
    return (int'(idx) + 1 >= n) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/sif_rr_arbiter.sv
// Round-robin selector: first requester at or after ptr, wrapping to index 0.
module sif_rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [2:0]       idx,
  output logic             any
);

  // Pass 1 scans ptr..N_REQ-1; pass 2 only finds something below ptr.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!any && req[i] && i >= int'(ptr)) begin
        any    = 1'b1;
        idx    = 3'(i);
        gnt[i] = 1'b1;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!any && req[i]) begin
        any    = 1'b1;
        idx    = 3'(i);
        gnt[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sif_xa_arbiter.sv
// Shares one SIF xa bus among N_REQ requesters, one transaction at a time,
// with round-robin acceptance and a fixed RD_LAT read-data latency.
module sif_xa_arbiter
  import sif_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int RD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ*SIF_AW-1:0] req_addr,
  input  logic [N_REQ*SIF_DW-1:0] req_wdata,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [SIF_DW-1:0]       rsp_rdata,
  output logic [SIF_AW-1:0]       xa_addr,
  output logic [SIF_DW-1:0]       xa_data_wr,
  output logic                    xa_wr_s,
  output logic                    xa_rd_s,
  input  logic [SIF_DW-1:0]       xa_data_rd,
  output logic                    busy,
  output logic [2:0]              grant_id
);

  sif_state_e        state_q, state_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [2:0]        id_q, id_d;
  logic [SIF_AW-1:0] addr_q, addr_d;
  logic [SIF_DW-1:0] wdata_q, wdata_d;
  logic [SIF_DW-1:0] rdata_q, rdata_d;
  logic              wr_s_q, wr_s_d;
  logic              rd_s_q, rd_s_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;

  logic [N_REQ-1:0]  gnt;
  logic [2:0]        gnt_idx;
  logic              gnt_any;

  sif_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    id_d        = id_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    wr_s_d      = 1'b0;
    rd_s_d      = 1'b0;
    rsp_valid_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
              we_d   = req_we[i];
              addr_d = req_addr[i*SIF_AW +: SIF_AW];
              // Reads leave the write-data bus at its last written value.
              if (req_we[i]) wdata_d = req_wdata[i*SIF_DW +: SIF_DW];
            end
          end
          id_d    = gnt_idx;
          ptr_d   = next_ptr(gnt_idx, N_REQ);
          wr_s_d  = we_d;
          rd_s_d  = !we_d;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (we_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = 3'(RD_LAT);
        end
      end
      ST_WAIT: begin
        if (cnt_q == 3'd1) begin
          rdata_d = xa_data_rd;
          cnt_d   = '0;
          state_d = ST_RESP;
          for (int i = 0; i < N_REQ; i++) rsp_valid_d[i] = (id_q == 3'(i));
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      id_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      wr_s_q      <= 1'b0;
      rd_s_q      <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      wr_s_q      <= wr_s_d;
      rd_s_q      <= rd_s_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Acceptance is combinational, so it is also masked while reset is held.
  assign req_ready  = (state_q == ST_IDLE && rst_n) ? gnt : '0;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rdata_q;
  assign xa_addr    = addr_q;
  assign xa_data_wr = wdata_q;
  assign xa_wr_s    = wr_s_q;
  assign xa_rd_s    = rd_s_q;
  assign busy       = (state_q != ST_IDLE);
  assign grant_id   = id_q;

endmodule

// File: tb/tb_sif_xa_arbiter.sv
// Bench for sif_xa_arbiter: table vectors, directed latency/reset sequences,
// and a randomized run against a timeline model of the arbiter.
module tb_sif_xa_arbiter;

  localparam int N = 4;
  localparam int RD_LAT = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_we = '0;
  logic [N*16-1:0] req_addr = '0;
  logic [N*16-1:0] req_wdata = '0;
  logic [15:0]     xa_data_rd;

  logic [N-1:0] req_ready, rsp_valid, req_ready3, rsp_valid3;
  logic [15:0]  rsp_rdata, xa_addr, xa_data_wr, rsp_rdata3, xa_addr3, xa_data_wr3;
  logic         xa_wr_s, xa_rd_s, busy, xa_wr_s3, xa_rd_s3, busy3;
  logic [2:0]   grant_id, grant_id3;

  sif_xa_arbiter #(.N_REQ(N), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .xa_addr(xa_addr),
    .xa_data_wr(xa_data_wr), .xa_wr_s(xa_wr_s), .xa_rd_s(xa_rd_s),
    .xa_data_rd(xa_data_rd), .busy(busy), .grant_id(grant_id)
  );

  sif_xa_arbiter #(.N_REQ(N), .RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready3),
    .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .xa_addr(xa_addr3),
    .xa_data_wr(xa_data_wr3), .xa_wr_s(xa_wr_s3), .xa_rd_s(xa_rd_s3),
    .xa_data_rd(xa_data_rd), .busy(busy3), .grant_id(grant_id3)
  );

  // Bus slave model: data is valid only in the cycle after the read strobe.
  logic        rd_seen = 1'b0;
  logic [15:0] rd_addr_m = '0;
  always @(posedge clk) begin
    rd_seen <= xa_rd_s;
    if (xa_rd_s) rd_addr_m <= xa_addr;
  end
  assign xa_data_rd = rd_seen ? (rd_addr_m ^ 16'h1230) : 16'hDEAD;

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return a ^ 16'h1230;
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic we, input logic [15:0] a, input logic [15:0] d);
    req_valid[i] = 1'b1;
    req_we[i] = we;
    req_addr[i*16 +: 16] = a;
    req_wdata[i*16 +: 16] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_strobes", {xa_wr_s, xa_rd_s}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_xa_addr", xa_addr, 0);
    chk("rst_xa_data_wr", xa_data_wr, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset applied");
  endtask

  typedef struct {
    logic [3:0] valid;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int widx;
    int p_m, busy_until, gt, strobe_t, rsp_t, rsp_id, win, last_gid;
    logic s_we;
    logic [15:0] s_addr, s_wdata, rsp_data, cur_addr, cur_wdata, last_rdata;
    logic [3:0] exp_ready, exp_rsp, drop_mask;

    tbl[0] = '{4'b0000, 4'b0000};
    tbl[1] = '{4'b1111, 4'b0001};
    tbl[2] = '{4'b1001, 4'b1000};
    tbl[3] = '{4'b1001, 4'b0001};
    tbl[4] = '{4'b0100, 4'b0100};
    tbl[5] = '{4'b0011, 4'b0001};
    tbl[6] = '{4'b0011, 4'b0010};
    tbl[7] = '{4'b1111, 4'b0100};
    tbl[8] = '{4'b1111, 4'b1000};

    do_reset();

    // Table vectors: all writes, pointer walks from 0 through the sequence.
    for (int i = 0; i < N; i++) begin
      req_addr[i*16 +: 16]  = 16'h0100 + 16'(i);
      req_wdata[i*16 +: 16] = 16'hA000 + 16'(i);
    end
    for (int v = 0; v < 9; v++) begin
      @(negedge clk);
      req_valid = tbl[v].valid;
      req_we = '1;
      #1;
      chk("tbl_ready", req_ready, tbl[v].exp);
      $display("vector %0d: valid=%b ready=%b expected=%b", v, tbl[v].valid, req_ready, tbl[v].exp);
      if (tbl[v].exp != 0) begin
        widx = 0;
        for (int i = 0; i < N; i++) if (tbl[v].exp[i]) widx = i;
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("tbl_wr_s", {xa_wr_s, xa_rd_s}, 2'b10);
        chk("tbl_xa_addr", xa_addr, 16'h0100 + 16'(widx));
        chk("tbl_xa_data_wr", xa_data_wr, 16'hA000 + 16'(widx));
      end
    end

    // Directed write from requester 2.
    @(negedge clk);
    req_valid = '0;
    set_req(2, 1'b1, 16'h0010, 16'hBEEF);
    #1;
    chk("wr_ready", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("wr_strobes_t1", {xa_wr_s, xa_rd_s}, 2'b10);
    chk("wr_xa_addr", xa_addr, 16'h0010);
    chk("wr_xa_data_wr", xa_data_wr, 16'hBEEF);
    chk("wr_grant_id", grant_id, 2);
    chk("wr_busy_t1", busy, 1);
    @(negedge clk);
    #1;
    chk("wr_strobes_t2", {xa_wr_s, xa_rd_s}, 2'b00);
    chk("wr_busy_t2", busy, 0);
    chk("wr_addr_hold", xa_addr, 16'h0010);
    $display("write req2 addr=%h data=%h", xa_addr, xa_data_wr);

    // Directed read from requester 0; its we flips after the grant.
    @(negedge clk);
    set_req(0, 1'b0, 16'h0004, 16'h5555);
    #1;
    chk("rd_ready", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    req_we[0] = 1'b1;
    #1;
    chk("rd_strobes_t1", {xa_wr_s, xa_rd_s}, 2'b01);
    chk("rd_xa_addr", xa_addr, 16'h0004);
    chk("rd_data_wr_hold", xa_data_wr, 16'hBEEF);
    @(negedge clk);
    #1;
    chk("rd_strobes_t2", {xa_wr_s, xa_rd_s}, 2'b00);
    chk("rd_rsp_t2", rsp_valid, 0);
    chk("rd_busy_t2", busy, 1);
    @(negedge clk);
    #1;
    chk("rd_rsp_t3", rsp_valid, 4'b0001);
    chk("rd_rdata_t3", rsp_rdata, 16'h1234);
    @(negedge clk);
    #1;
    chk("rd_rsp_t4", rsp_valid, 0);
    chk("rd_rdata_hold", rsp_rdata, 16'h1234);
    chk("rd_busy_t4", busy, 0);
    $display("read req0 addr=0004 rdata=%h", rsp_rdata);

    // Fairness: all four valid writes, one grant every second cycle.
    do_reset();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      req_valid = '1;
      req_we = '1;
      #1;
      chk("fair_ready", req_ready, (c % 2 == 0) ? (4'b0001 << ((c / 2) % 4)) : 4'b0000);
      $display("fairness cycle %0d ready=%b", c, req_ready);
    end
    req_valid = '0;

    // Reset in the middle of an RD_LAT=3 read wait.
    do_reset();
    @(negedge clk);
    set_req(1, 1'b0, 16'h0040, 16'h0000);
    #1;
    chk("rst3_ready", req_ready3, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("rst3_rd_s", xa_rd_s3, 1);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst3_busy_wait", busy3, 1);
    req_valid = '1;
    req_we = '1;
    rst_n = 1'b0;
    #1;
    chk("rst3_strobes", {xa_wr_s3, xa_rd_s3}, 0);
    chk("rst3_busy", busy3, 0);
    chk("rst3_rsp", rsp_valid3, 0);
    chk("rst3_ready_in_rst", req_ready3, 0);
    chk("rst3_grant_id", grant_id3, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("rst3_rsp_held", rsp_valid3, 0);
    end
    rst_n = 1'b1;
    #1;
    chk("rst3_first_grant", req_ready3, 4'b0001);
    chk("rst1_first_grant", req_ready, 4'b0001);
    @(negedge clk);
    #1;
    chk("rst3_rsp_after", rsp_valid3, 0);
    chk("rst3_wr_s_after", xa_wr_s3, 1);
    req_valid = '0;
    $display("reset-in-wait sequence done");

    // Randomized traffic against a timeline model.
    do_reset();
    p_m = 0; busy_until = 0; gt = -100; strobe_t = -1; rsp_t = -1; rsp_id = 0;
    last_gid = 0; s_we = 1'b0; s_addr = '0; s_wdata = '0; rsp_data = '0;
    cur_addr = '0; cur_wdata = '0; last_rdata = '0; drop_mask = '0;
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      req_valid = req_valid & ~drop_mask;
      for (int i = 0; i < N; i++) if (drop_mask[i]) req_we[i] = ~req_we[i];
      drop_mask = '0;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(3) == 0)
          set_req(i, 1'($urandom_range(1)), 16'($urandom), 16'($urandom));
        else if (req_valid[i] && $urandom_range(15) == 0)
          req_valid[i] = 1'b0;
      end
      #1;
      exp_ready = '0;
      win = -1;
      if (t >= busy_until) begin
        for (int k = 0; k < N; k++)
          if (win < 0 && req_valid[(p_m + k) % N]) win = (p_m + k) % N;
      end
      if (win >= 0) begin
        exp_ready[win] = 1'b1;
        s_we = req_we[win];
        s_addr = req_addr[win*16 +: 16];
        s_wdata = req_wdata[win*16 +: 16];
        strobe_t = t + 1;
        rsp_t = s_we ? -1 : t + RD_LAT + 2;
        rsp_id = win;
        rsp_data = mem_f(s_addr);
        busy_until = t + (s_we ? 2 : RD_LAT + 3);
        gt = t;
        p_m = (win + 1) % N;
        drop_mask[win] = 1'b1;
      end
      if (t == strobe_t) begin
        cur_addr = s_addr;
        if (s_we) cur_wdata = s_wdata;
      end
      if (t == rsp_t) last_rdata = rsp_data;
      exp_rsp = (t == rsp_t) ? (4'b0001 << rsp_id) : 4'b0000;
      chk("rnd_ready", req_ready, exp_ready);
      chk("rnd_wr_s", xa_wr_s, (t == strobe_t) && s_we);
      chk("rnd_rd_s", xa_rd_s, (t == strobe_t) && !s_we);
      chk("rnd_xa_addr", xa_addr, cur_addr);
      chk("rnd_xa_data_wr", xa_data_wr, cur_wdata);
      chk("rnd_rsp_valid", rsp_valid, exp_rsp);
      chk("rnd_rsp_rdata", rsp_rdata, last_rdata);
      chk("rnd_busy", busy, (t > gt) && (t < busy_until));
      chk("rnd_grant_id", grant_id, last_gid);
      if (win >= 0) begin
        last_gid = win;
        $display("cycle %0d grant req%0d %s addr=%h", t, win, s_we ? "write" : "read", s_addr);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
